// File: rtl/conbus_test_pkg.sv
// Shared definitions for the conbus test slave and its LFSR.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conbus_test_pkg;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Wishbone cycle type identifiers; the slave treats every access as classic
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone data and byte-select widths
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

endpackage

// File: rtl/conbus_lfsr16.sv
// 16-bit Galois LFSR, free-running, loaded with seed during reset.
// Latency: new state every clock edge out of reset.
// Backpressure: none; advances unconditionally.
// Ports: clk, rst_n (async active-low), state (current LFSR value).
module conbus_lfsr16
    import conbus_test_pkg::*;
#(
    parameter logic [15:0] seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/conbus_test_slave.sv
// Wishbone classic responder backed by a 2^aw x 32 RAM, with random wait states,
// read/write counters and a sticky master protocol-violation flag.
// Latency: ack 1..maxwait+1 cycles after the request is sampled; one access per 2+W cycles.
// Backpressure: wait states from the LFSR; dropping cyc/stb during WAIT aborts the access.
// Ports: sys_clk, sys_rst_n, wishbone slave (adr, dat_w, dat_r, sel, we, cti, cyc, stb, ack),
//        status (nreads, nwrites, viol, viol_id).
module conbus_test_slave
    import conbus_test_pkg::*;
#(
    parameter int          id      = 0,
    parameter int          aw      = 4,
    parameter int          maxwait = 3,
    parameter logic [15:0] seed    = 16'hACE1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] adr,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r,
    input  logic [3:0]  sel,
    input  logic        we,
    input  logic [2:0]  cti,
    input  logic        cyc,
    input  logic        stb,
    output logic        ack,
    output logic [31:0] nreads,
    output logic [31:0] nwrites,
    output logic        viol,
    output logic [7:0]  viol_id
);

    localparam int         DEPTH = 1 << aw;
    localparam logic [7:0] WMOD  = 8'(maxwait + 1);

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [7:0]  wcnt, wcnt_nxt;
    logic [7:0]  wait_w;
    logic        req;
    logic        latch;
    logic        enter_ack;
    logic        viol_set;

    logic [31:0] lat_adr, lat_dat;
    logic [3:0]  lat_sel;
    logic        lat_we;

    // Fields of the transfer completing on this edge. A zero-wait access goes
    // straight from IDLE to ACK, before the latches hold it, so use the bus.
    logic [31:0] x_adr, x_dat;
    logic [3:0]  x_sel;
    logic        x_we;
    logic [aw-1:0] x_idx;

    logic [31:0] mem [DEPTH];

    // cti is accepted but has no effect; upper LFSR bits do not feed the wait count
    logic unused_ok;
    assign unused_ok = ^{cti, lfsr[15:8]};

    conbus_lfsr16 #(.seed(seed)) u_lfsr (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .state (lfsr)
    );

    assign req     = cyc & stb;
    assign wait_w  = lfsr[7:0] % WMOD;
    assign ack     = (state == ACK);
    assign viol_id = 8'(id);

    assign x_adr = latch ? adr   : lat_adr;
    assign x_dat = latch ? dat_w : lat_dat;
    assign x_sel = latch ? sel   : lat_sel;
    assign x_we  = latch ? we    : lat_we;
    assign x_idx = x_adr[aw+1:2];

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        latch     = 1'b0;
        enter_ack = 1'b0;
        viol_set  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch    = 1'b1;
                    wcnt_nxt = wait_w;
                    if (wait_w == 8'd0) begin
                        state_nxt = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // master abort: no ack, no write, no count
                    state_nxt = IDLE;
                end else begin
                    viol_set = (adr != lat_adr) || (we != lat_we) || (sel != lat_sel) ||
                               (lat_we && (dat_w != lat_dat));
                    if (wcnt == 8'd1) begin
                        state_nxt = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt - 8'd1;
                    end
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            wcnt    <= 8'd0;
            lat_adr <= 32'd0;
            lat_dat <= 32'd0;
            lat_sel <= 4'd0;
            lat_we  <= 1'b0;
            dat_r   <= 32'd0;
            nreads  <= 32'd0;
            nwrites <= 32'd0;
            viol    <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (latch) begin
                lat_adr <= adr;
                lat_dat <= dat_w;
                lat_sel <= sel;
                lat_we  <= we;
            end
            dat_r <= (enter_ack && !x_we) ? mem[x_idx] : 32'd0;
            if (enter_ack) begin
                if (x_we) begin
                    if (nwrites != 32'hFFFF_FFFF) nwrites <= nwrites + 32'd1;
                end else begin
                    if (nreads != 32'hFFFF_FFFF) nreads <= nreads + 32'd1;
                end
            end
            if (viol_set) viol <= 1'b1;
        end
    end

    // RAM has no reset; gating with sys_rst_n keeps a request seen during
    // reset from writing.
    always_ff @(posedge sys_clk) begin
        if (enter_ack && x_we && sys_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (x_sel[i]) mem[x_idx][8*i +: 8] <= x_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_conbus_test_slave.sv
module tb_conbus_test_slave;
    import conbus_test_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] adr [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic [3:0]  sel [2];
    logic        we [2];
    logic [2:0]  cti [2];
    logic        cyc [2];
    logic        stb [2];
    logic        ack [2];
    logic [31:0] nreads [2];
    logic [31:0] nwrites [2];
    logic        viol [2];
    logic [7:0]  viol_id [2];

    int ntests = 0;
    int nfail  = 0;

    logic [15:0] m_lfsr;
    logic [31:0] mem_m [16];
    int          n_r = 0;
    int          n_w = 0;

    always #5 sys_clk = ~sys_clk;

    // dut 0: fixed latency; dut 1: up to 3 random wait states
    conbus_test_slave #(.id(0), .aw(4), .maxwait(0), .seed(16'h1234)) u_fix (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .adr(adr[0]), .dat_w(dat_w[0]),
        .dat_r(dat_r[0]), .sel(sel[0]), .we(we[0]), .cti(cti[0]), .cyc(cyc[0]),
        .stb(stb[0]), .ack(ack[0]), .nreads(nreads[0]), .nwrites(nwrites[0]),
        .viol(viol[0]), .viol_id(viol_id[0]));

    conbus_test_slave #(.id(7), .aw(4), .maxwait(3), .seed(16'hACE1)) u_rnd (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .adr(adr[1]), .dat_w(dat_w[1]),
        .dat_r(dat_r[1]), .sel(sel[1]), .we(we[1]), .cti(cti[1]), .cyc(cyc[1]),
        .stb(stb[1]), .ack(ack[1]), .nreads(nreads[1]), .nwrites(nwrites[1]),
        .viol(viol[1]), .viol_id(viol_id[1]));

    // Reference LFSR for u_rnd: Galois, taps x^16+x^14+x^13+x^11
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m_lfsr <= 16'hACE1;
        else            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // wait states u_rnd will pick if a request is sampled on the next edge
    function automatic int w_now();
        return int'(m_lfsr[7:0]) % 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One access; called #1 after an edge with the slave idle.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dw,
                        input logic [3:0] s, input int exp_lat, input string tag,
                        output logic [31:0] rd);
        int   lat;
        logic got;
        adr[d] = a; dat_w[d] = dw; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            got = ack[d];
        end
        rd = dat_r[d];
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        tick();
        chk({tag, " ack one cycle"}, {31'd0, ack[d]}, 32'd0);
        chk({tag, " dat_r idle"}, dat_r[d], 32'd0);
    endtask

    initial begin
        logic [31:0] rd, ra, rdw;
        logic        rw;
        logic [3:0]  rs;
        int          idx, k;
        logic        got;

        sys_rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            adr[d] = '0; dat_w[d] = '0; sel[d] = '0; we[d] = 1'b0;
            cyc[d] = 1'b0; stb[d] = 1'b0;
        end
        cti[0] = CTI_CLASSIC;
        cti[1] = CTI_EOB;
        repeat (2) @(posedge sys_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset ack",     {31'd0, ack[d]},  32'd0);
            chk("reset dat_r",   dat_r[d],         32'd0);
            chk("reset nreads",  nreads[d],        32'd0);
            chk("reset nwrites", nwrites[d],       32'd0);
            chk("reset viol",    {31'd0, viol[d]}, 32'd0);
        end
        chk("viol_id 0", {24'd0, viol_id[0]}, 32'd0);
        chk("viol_id 1", {24'd0, viol_id[1]}, 32'd7);
        sys_rst_n = 1'b1;
        tick();

        // fixed-latency write then read
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1, "t1 write", rd);
        chk("t1 nwrites", nwrites[0], 32'd1);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 1, "t1 read", rd);
        chk("t1 read data", rd, 32'hDEADBEEF);
        chk("t1 nreads", nreads[0], 32'd1);

        // byte lanes: lanes 0 and 2 overwritten
        xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF,    1, "t2 write full", rd);
        xfer(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1, "t2 write lanes", rd);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1, "t2 read", rd);
        chk("t2 read data", rd, 32'h11BB33DD);

        // aliasing: 0x40 and 0x03 both map to word 0
        xfer(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1, "t3 write", rd);
        xfer(0, 1'b0, 32'h03, 32'h0, 4'hF, 1, "t3 read", rd);
        chk("t3 alias data", rd, 32'hCAFEF00D);
        chk("t3 nwrites", nwrites[0], 32'd4);
        chk("t3 nreads",  nreads[0],  32'd3);

        // stb without cyc in IDLE is ignored
        adr[0] = 32'h8; stb[0] = 1'b1; cyc[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stb-only no ack", {31'd0, ack[0]}, 32'd0);
        end
        stb[0] = 1'b0;
        chk("stb-only nreads", nreads[0], 32'd3);
        tick();

        // random wait states against a memory model
        for (int i = 0; i < 16; i++) begin
            rdw = $urandom;
            xfer(1, 1'b1, 32'(i * 4), rdw, 4'hF, 1 + w_now(), "t4 init", rd);
            mem_m[i] = rdw;
            n_w++;
        end
        for (int i = 0; i < 1000; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rdw = $urandom;
            rs  = 4'($urandom_range(0, 15));
            idx = int'(ra[5:2]);
            xfer(1, rw, ra, rdw, rs, 1 + w_now(), "t4 rand", rd);
            if (rw) begin
                for (int b = 0; b < 4; b++)
                    if (rs[b]) mem_m[idx][8*b +: 8] = rdw[8*b +: 8];
                n_w++;
            end else begin
                chk("t4 read data", rd, mem_m[idx]);
                n_r++;
            end
        end
        chk("t4 nwrites", nwrites[1], 32'(n_w));
        chk("t4 nreads",  nreads[1],  32'(n_r));
        chk("t4 viol",    {31'd0, viol[1]}, 32'd0);

        // abort after one wait cycle
        k = 0;
        while (w_now() == 0 && k < 50) begin tick(); k++; end
        chk("t5 found W>=1", {31'd0, (w_now() != 0)}, 32'd1);
        adr[1] = 32'h14; dat_w[1] = 32'h5A5A5A5A; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        chk("t5 no ack in wait", {31'd0, ack[1]}, 32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5 no ack after abort", {31'd0, ack[1]}, 32'd0);
        end
        chk("t5 nwrites", nwrites[1], 32'(n_w));
        xfer(1, 1'b0, 32'h14, 32'h0, 4'hF, 1 + w_now(), "t5 read", rd);
        chk("t5 word unchanged", rd, mem_m[5]);
        n_r++;

        // address change during WAIT sets viol
        k = 0;
        while (w_now() == 0 && k < 50) begin tick(); k++; end
        adr[1] = 32'h4; sel[1] = 4'hF; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        chk("t6 viol before change", {31'd0, viol[1]}, 32'd0);
        adr[1] = 32'h8;
        tick();
        chk("t6 viol set", {31'd0, viol[1]}, 32'd1);
        got = ack[1];
        k = 0;
        while (!got && k < 8) begin tick(); k++; got = ack[1]; end
        chk("t6 ack after viol", {31'd0, got}, 32'd1);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        n_r++;
        tick();
        xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 1 + w_now(), "t6 clean read", rd);
        n_r++;
        chk("t6 clean data", rd, mem_m[2]);
        chk("t6 viol sticky", {31'd0, viol[1]}, 32'd1);
        chk("t6 nreads", nreads[1], 32'(n_r));

        // reset pulse mid-WAIT
        k = 0;
        while (w_now() == 0 && k < 50) begin tick(); k++; end
        adr[1] = 32'h14; dat_w[1] = 32'h77777777; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        sys_rst_n = 1'b0;
        #1;
        chk("t6 rst ack",     {31'd0, ack[1]},  32'd0);
        chk("t6 rst viol",    {31'd0, viol[1]}, 32'd0);
        chk("t6 rst nreads",  nreads[1],        32'd0);
        chk("t6 rst nwrites", nwrites[1],       32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        xfer(1, 1'b0, 32'h14, 32'h0, 4'hF, 1 + w_now(), "t6 post-rst read", rd);
        chk("t6 word survives reset", rd, mem_m[5]);
        chk("t6 post-rst nreads",  nreads[1],  32'd1);
        chk("t6 post-rst nwrites", nwrites[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
